reg_file_dump: RTL and testbench

- Register file directly upstream of the 16-bit ALU in the single-cycle datapath.
- Drives the ALU `a` operand from `rs_data` and the `b` operand from `rt_data`; the ALU result returns through the write port.
- Register 0 is hardwired to zero. Same-cycle writes bypass to the read ports.
- A sequential dump engine streams every register out for bench/debug observation without stalling the datapath.

---
 rtl/reg_file_dump.sv | 109 ++++++++++
 tb/tb_reg_file_dump.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reg_file_dump.sv
// Register file feeding the ALU operands, with r0 hardwired to zero, write-to-read bypass,
// and a one-pass dump engine that streams every stored register for debug observation.
module reg_file_dump #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               dump_addr_q, dump_addr_d;
    logic                            dump_busy_q, dump_busy_d;
    logic                            dump_valid_q, dump_valid_d;
    logic                            dump_done_q, dump_done_d;

    logic wr_en;
    assign wr_en = we && (wr_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[wr_addr] = wr_data;
        regs_d[0] = '0;
    end

    // Bypass only when the port index is nonzero, which also excludes writes to r0.
    always_comb begin
        rs_data = '0;
        if (rs_addr != '0) rs_data = (wr_en && wr_addr == rs_addr) ? wr_data : regs_q[rs_addr];
    end

    always_comb begin
        rt_data = '0;
        if (rt_addr != '0) rt_data = (wr_en && wr_addr == rt_addr) ? wr_data : regs_q[rt_addr];
    end

    always_comb begin
        state_d      = state_q;
        dump_addr_d  = '0;
        dump_busy_d  = 1'b0;
        dump_valid_d = 1'b0;
        dump_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d      = SCAN;
                    dump_busy_d  = 1'b1;
                    dump_valid_d = 1'b1;
                end
            end
            SCAN: begin
                if (dump_addr_q == LAST_IDX) begin
                    state_d     = DONE;
                    dump_done_d = 1'b1;
                end else begin
                    dump_addr_d  = dump_addr_q + ADDR_W'(1);
                    dump_busy_d  = 1'b1;
                    dump_valid_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q       <= '0;
            state_q      <= IDLE;
            dump_addr_q  <= '0;
            dump_busy_q  <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            state_q      <= state_d;
            dump_addr_q  <= dump_addr_d;
            dump_busy_q  <= dump_busy_d;
            dump_valid_q <= dump_valid_d;
            dump_done_q  <= dump_done_d;
        end
    end

    // Dump reads live storage (no bypass), so a same-cycle write to this index shows the old value.
    assign dump_data  = dump_valid_q ? regs_q[dump_addr_q] : '0;
    assign dump_addr  = dump_addr_q;
    assign dump_busy  = dump_busy_q;
    assign dump_valid = dump_valid_q;
    assign dump_done  = dump_done_q;

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed bench for reg_file_dump: reset, read/write, r0, bypass, full dump, dump with
// concurrent writes and reset abort.
module tb_reg_file_dump;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rs_addr, rt_addr, wr_addr, dump_addr;
    logic [15:0] rs_data, rt_data, wr_data, dump_data;
    logic        we, dump_start, dump_busy, dump_valid, dump_done;

    int checks = 0;
    int errors = 0;
    logic [15:0] mdl [8];

    reg_file_dump #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic check_dump_idle(input string tag);
        check({tag, "_busy"},  {31'd0, dump_busy},  32'd0);
        check({tag, "_valid"}, {31'd0, dump_valid}, 32'd0);
        check({tag, "_addr"},  {29'd0, dump_addr},  32'd0);
        check({tag, "_data"},  {16'd0, dump_data},  32'd0);
    endtask

    task automatic check_entry(input int k, input logic [15:0] exp);
        check($sformatf("dump%0d_valid", k), {31'd0, dump_valid}, 32'd1);
        check($sformatf("dump%0d_busy", k),  {31'd0, dump_busy},  32'd1);
        check($sformatf("dump%0d_addr", k),  {29'd0, dump_addr},  k);
        check($sformatf("dump%0d_data", k),  {16'd0, dump_data},  {16'd0, exp});
        check($sformatf("dump%0d_done", k),  {31'd0, dump_done},  32'd0);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0;
        rs_addr = '0; rt_addr = '0; dump_start = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check_dump_idle("por");
        check("por_done", {31'd0, dump_done}, 32'd0);

        // Reset clears a preloaded register
        wr(3'd3, 16'h1234);
        rs_addr = 3'd3; #1;
        check("preload_r3", {16'd0, rs_data}, 32'h1234);
        rst = 1'b1; tick(); rst = 1'b0; #1;
        check("reset_r3", {16'd0, rs_data}, 32'h0000);
        check_dump_idle("reset");
        check("reset_done", {31'd0, dump_done}, 32'd0);

        // Write then read on both ports
        wr(3'd5, 16'hBEEF);
        rs_addr = 3'd5; rt_addr = 3'd5; #1;
        check("rd_rs_r5", {16'd0, rs_data}, 32'hBEEF);
        check("rd_rt_r5", {16'd0, rt_data}, 32'hBEEF);

        // r0 hardwired, including during a same-cycle write
        we = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; rs_addr = 3'd0; rt_addr = 3'd0; #1;
        check("r0_bypass_rs", {16'd0, rs_data}, 32'h0000);
        check("r0_bypass_rt", {16'd0, rt_data}, 32'h0000);
        tick(); we = 1'b0; #1;
        check("r0_after", {16'd0, rs_data}, 32'h0000);

        // Bypass on both ports
        wr(3'd2, 16'h0001);
        rs_addr = 3'd2; rt_addr = 3'd2; #1;
        check("r2_pre", {16'd0, rs_data}, 32'h0001);
        we = 1'b1; wr_addr = 3'd2; wr_data = 16'h00A5; #1;
        check("byp_rs", {16'd0, rs_data}, 32'h00A5);
        check("byp_rt", {16'd0, rt_data}, 32'h00A5);
        rs_addr = 3'd5; #1;
        check("nobyp_rs_r5", {16'd0, rs_data}, 32'hBEEF);
        tick(); we = 1'b0; rs_addr = 3'd2; #1;
        check("byp_stored", {16'd0, rs_data}, 32'h00A5);

        // Full dump with a second dump_start in cycle N+3
        for (int i = 1; i < 8; i++) begin
            wr(3'(i), 16'(16'h0011 * i));
            mdl[i] = 16'(16'h0011 * i);
        end
        dump_start = 1'b1; tick(); dump_start = 1'b0; #1;
        for (int k = 0; k < 8; k++) begin
            check_entry(k, mdl[k]);
            if (k == 2) dump_start = 1'b1;
            tick();
            dump_start = 1'b0;
            #1;
        end
        check("full_done", {31'd0, dump_done}, 32'd1);
        check_dump_idle("full_donecyc");
        tick();
        check("full_done_pulse", {31'd0, dump_done}, 32'd0);
        check_dump_idle("full_after");

        // Dump with concurrent writes: r6 ahead of scan, r3 while it is being dumped
        dump_start = 1'b1; tick(); dump_start = 1'b0; #1;
        for (int k = 0; k < 8; k++) begin
            check_entry(k, mdl[k]);
            if (k == 2) begin we = 1'b1; wr_addr = 3'd6; wr_data = 16'hCAFE; end
            if (k == 3) begin we = 1'b1; wr_addr = 3'd3; wr_data = 16'h5555; end
            tick();
            if (k == 2) mdl[6] = 16'hCAFE;
            if (k == 3) mdl[3] = 16'h5555;
            we = 1'b0;
            #1;
        end
        check("cw_done", {31'd0, dump_done}, 32'd1);
        rs_addr = 3'd3; rt_addr = 3'd6; #1;
        check("cw_r3", {16'd0, rs_data}, 32'h5555);
        check("cw_r6", {16'd0, rt_data}, 32'hCAFE);
        tick();

        // Reset while index 4 is dumped
        dump_start = 1'b1; tick(); dump_start = 1'b0; #1;
        for (int k = 0; k < 5; k++) begin
            check_entry(k, mdl[k]);
            if (k < 4) tick();
        end
        rst = 1'b1; tick(); rst = 1'b0; rs_addr = 3'd6; #1;
        check_dump_idle("abort");
        check("abort_done0", {31'd0, dump_done}, 32'd0);
        check("abort_r6", {16'd0, rs_data}, 32'h0000);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("abort_done%0d", c), {31'd0, dump_done}, 32'd0);
            check($sformatf("abort_busy%0d", c), {31'd0, dump_busy}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
